// File: rtl/pwm_burst_4b_if.sv
// pwm_burst_4b_if: control, counter-side and status signals of the burst PWM generator
interface pwm_burst_4b_if #(
  parameter int CNT_W = 8
);
  logic             START;
  logic             STOP;
  logic [3:0]       DUTY;
  logic [CNT_W-1:0] NPULSE;
  logic [3:0]       Q;
  logic             CO;
  logic             LD_OUT;
  logic [3:0]       D_OUT;
  logic             CE_OUT;
  logic             PWM;
  logic             BUSY;
  logic             DONE;
  modport master (
    output START, STOP, DUTY, NPULSE, Q, CO,
    input  LD_OUT, D_OUT, CE_OUT, PWM, BUSY, DONE
  );
  modport slave (
    input  START, STOP, DUTY, NPULSE, Q, CO,
    output LD_OUT, D_OUT, CE_OUT, PWM, BUSY, DONE
  );
endinterface

// File: rtl/pwm_burst_4b.sv
// pwm_burst_4b: burst PWM generator driving a 4-bit up counter.
// Define PWM_BURST_CONT_EN to make NPULSE==0 run continuously until STOP.
module pwm_burst_4b #(
  parameter int CNT_W = 8
) (
  input logic           CLK,
  input logic           RST,
  pwm_burst_4b_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARM, RUN, FIN} state_t;
  state_t           state;
  logic [3:0]       duty_act;
  logic [CNT_W-1:0] rem;
  logic             cont;
  logic             go;
  logic             last;
`ifdef PWM_BURST_CONT_EN
  always_ff @(posedge CLK or posedge RST)
    if (RST) cont <= 1'b0;
    else if (state == IDLE && bus.START && !bus.STOP) cont <= bus.NPULSE == '0;
  assign go = bus.START;
`else
  assign cont = 1'b0;
  assign go = bus.START && bus.NPULSE != '0;
`endif
  assign last = !cont && rem == CNT_W'(1);
  assign bus.D_OUT = 4'b0000;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      duty_act   <= '0;
      rem        <= '0;
      bus.PWM    <= 1'b0;
      bus.BUSY   <= 1'b0;
      bus.DONE   <= 1'b0;
      bus.LD_OUT <= 1'b0;
      bus.CE_OUT <= 1'b0;
    end else begin
      bus.DONE   <= 1'b0;
      bus.LD_OUT <= 1'b0;
      if (bus.STOP) begin
        state      <= IDLE;
        bus.PWM    <= 1'b0;
        bus.CE_OUT <= 1'b0;
        bus.BUSY   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (go) begin
              state      <= ARM;
              duty_act   <= bus.DUTY;
              rem        <= bus.NPULSE;
              bus.LD_OUT <= 1'b1;
              bus.BUSY   <= 1'b1;
            end else begin
              bus.DONE <= bus.START;
            end
          end
          ARM: begin
            state      <= RUN;
            bus.CE_OUT <= 1'b1;
          end
          RUN: begin
            // PWM lags Q by one clock; the final boundary forces it low for FIN
            bus.PWM <= !(bus.CO && last) && (bus.Q < duty_act);
            if (bus.CO) begin
              duty_act <= bus.DUTY;
              if (rem != '0) rem <= rem - CNT_W'(1);
              if (last) begin
                state      <= FIN;
                bus.DONE   <= 1'b1;
                bus.CE_OUT <= 1'b0;
                bus.BUSY   <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pwm_burst_4b.sv
// tb_pwm_burst_4b: directed bench with a cycle-indexed burst model and an up-counter model
module tb_pwm_burst_4b;
  localparam int CNT_W = 8;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int total = 0;
  int bad = 0;
  int pwm_hi = 0, ce_hi = 0, done_cnt = 0, ld_cnt = 0;
  int k = -1;
  int n = 0;
  bit cont_m = 1'b0;
  bit zdone = 1'b0;
  int duty_at [0:1023];
  logic [3:0] q;

  pwm_burst_4b_if #(.CNT_W(CNT_W)) bus();
  pwm_burst_4b #(.CNT_W(CNT_W)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

  always #5 CLK = ~CLK;

  always_ff @(posedge CLK or posedge RST)
    if (RST) q <= 4'h0;
    else if (bus.LD_OUT) q <= bus.D_OUT;
    else if (bus.CE_OUT) q <= q + 4'h1;
  assign bus.Q = q;
  assign bus.CO = (q == 4'hf);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // k = index of the current cycle within a burst: cycle 1 follows the START edge
  always @(posedge CLK) begin
    zdone = 1'b0;
    if (RST || bus.STOP) k = -1;
    else if (k < 0) begin
      if (bus.START) begin
`ifdef PWM_BURST_CONT_EN
        cont_m = (bus.NPULSE == 0);
`endif
        if (bus.NPULSE != 0 || cont_m) begin
          k = 1;
          n = int'(bus.NPULSE);
          duty_at[0] = int'(bus.DUTY);
        end else zdone = 1'b1;
      end
    end else if (!cont_m && k == 16 * n + 2) k = -1;
    else begin
      duty_at[k % 1024] = int'(bus.DUTY);
      k++;
    end
  end

  always @(posedge CLK) begin
    #2;
    begin : cmp
      int last, s, p, dp;
      logic e_pwm;
      last = cont_m ? 32'h7fffffff : 16 * n + 1;
      s = k - 3;
      p = (s < 0) ? 0 : s / 16;
      dp = (p == 0) ? duty_at[0] : duty_at[(1 + 16 * p) % 1024];
      e_pwm = (k >= 3 && k <= last) && ((s % 16) < dp);
      chk("ld_out", 32'(bus.LD_OUT), 32'(k == 1));
      chk("ce_out", 32'(bus.CE_OUT), 32'(k >= 2 && k <= last));
      chk("busy", 32'(bus.BUSY), 32'(k >= 1 && k <= last));
      chk("done", 32'(bus.DONE), 32'(zdone || (!cont_m && k == 16 * n + 2)));
      chk("pwm", 32'(bus.PWM), 32'(e_pwm));
      chk("d_out", 32'(bus.D_OUT), 32'd0);
      if (bus.PWM === 1'b1) pwm_hi++;
      if (bus.CE_OUT === 1'b1) ce_hi++;
      if (bus.DONE === 1'b1) done_cnt++;
      if (bus.LD_OUT === 1'b1) ld_cnt++;
    end
  end

  task automatic clr();
    pwm_hi = 0; ce_hi = 0; done_cnt = 0; ld_cnt = 0;
  endtask

  task automatic cycles(input int c);
    repeat (c) @(negedge CLK);
  endtask

  task automatic start(input int d, input int np);
    @(negedge CLK);
    clr();
    bus.DUTY = 4'(d);
    bus.NPULSE = CNT_W'(np);
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
  endtask

  task automatic tally(input string nm, input int p, input int c, input int dn);
    chk({nm, "_pwm_hi"}, p == -1 ? 0 : pwm_hi, p == -1 ? 0 : p);
    chk({nm, "_ce_hi"}, ce_hi, c);
    chk({nm, "_done"}, done_cnt, dn);
  endtask

  initial begin
    bus.START = 1'b0; bus.STOP = 1'b0; bus.DUTY = 4'h0; bus.NPULSE = '0;
    #1 RST = 1'b1;
    cycles(2);
    chk("rst_busy", 32'(bus.BUSY), 0);
    chk("rst_pwm", 32'(bus.PWM), 0);
    chk("rst_ce", 32'(bus.CE_OUT), 0);
    chk("rst_ld", 32'(bus.LD_OUT), 0);
    chk("rst_done", 32'(bus.DONE), 0);
    RST = 1'b0;
    cycles(2);
    // duty 4, two periods
    start(4, 2); cycles(40);
    tally("d4n2", 8, 32, 1);
    chk("d4n2_ld", ld_cnt, 1);
    chk("d4n2_ce_after", 32'(bus.CE_OUT), 0);
    // duty extremes
    start(0, 1); cycles(20);
    tally("d0", 0, 16, 1);
    start(15, 1); cycles(20);
    tally("d15", 15, 16, 1);
    // duty change at Q=7 of the first period only affects later periods
    start(4, 3); cycles(8);
    chk("dchg_q", 32'(q), 7);
    bus.DUTY = 4'd10;
    cycles(45);
    tally("dchg", 24, 48, 1);
    // STOP at Q=5 of the second period
    start(6, 5); cycles(22);
    chk("stop_q", 32'(q), 5);
    bus.STOP = 1'b1;
    cycles(1);
    bus.STOP = 1'b0;
    chk("stop_busy", 32'(bus.BUSY), 0);
    chk("stop_ce", 32'(bus.CE_OUT), 0);
    chk("stop_pwm", 32'(bus.PWM), 0);
    cycles(20);
    chk("stop_pwm_hi", pwm_hi, 11);
    chk("stop_done", done_cnt, 0);
    start(3, 1); cycles(20);
    tally("restart", 3, 16, 1);
    // NPULSE == 0
    start(5, 0); cycles(5);
`ifdef PWM_BURST_CONT_EN
    cycles(16 * 42);
    chk("cont_long", 32'(ce_hi >= 640), 1);
    bus.STOP = 1'b1;
    cycles(1);
    bus.STOP = 1'b0;
    cycles(5);
    chk("cont_done", done_cnt, 0);
    chk("cont_busy", 32'(bus.BUSY), 0);
`else
    tally("np0", 0, 0, 1);
    chk("np0_ld", ld_cnt, 0);
`endif
    // STOP beats START
    @(negedge CLK);
    clr();
    bus.NPULSE = CNT_W'(2); bus.START = 1'b1; bus.STOP = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0; bus.STOP = 1'b0;
    cycles(3);
    chk("ss_ld", ld_cnt, 0);
    chk("ss_busy", 32'(bus.BUSY), 0);
    // START while busy is ignored
    start(2, 1); cycles(4);
    bus.NPULSE = CNT_W'(3); bus.START = 1'b1;
    cycles(1);
    bus.START = 1'b0;
    cycles(20);
    tally("busy_start", 2, 16, 1);
    // async reset mid-run
    start(12, 2); cycles(9);
    chk("pre_rst_pwm", 32'(bus.PWM), 1);
    #1 RST = 1'b1;
    #1;
    chk("async_pwm", 32'(bus.PWM), 0);
    chk("async_busy", 32'(bus.BUSY), 0);
    chk("async_ce", 32'(bus.CE_OUT), 0);
    chk("async_ld", 32'(bus.LD_OUT), 0);
    cycles(2);
    RST = 1'b0;
    clr();
    cycles(40);
    tally("post_rst", -1, 0, 0);
    chk("post_rst_busy", 32'(bus.BUSY), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_burst_4b.md
Name: pwm_burst_4b

Overview:
- Downstream consumer of the 4-bit loadable up/down counter (CLK, RST_, M, LD, CE, D, Q, CO).
- Compares the counter's Q against a programmable duty value to produce a registered PWM waveform; one PWM period is 16 counter steps.
- Counts CO terminal-count events to emit a burst of NPULSE periods, then stops the counter and reports DONE.
- Also drives the counter's LD, D and CE so each burst starts phase-aligned at Q=0.

Parameters:
- CNT_W, 8, width of NPULSE and the internal remaining-periods counter.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous active-high reset.
- START  input  1  one-cycle request to begin a burst; sampled only in IDLE.
- STOP  input  1  abort; highest priority after RST.
- DUTY  input  4  requested high-time in counter steps (0..15).
- NPULSE  input  CNT_W  number of PWM periods in the burst.
- Q  input  4  counter value.
- CO  input  1  counter terminal-count (high when Q==4'b1111 counting up).
- LD_OUT  output  1  to counter LD.
- D_OUT  output  4  to counter D; constant 4'b0000.
- CE_OUT  output  1  to counter CE.
- PWM  output  1  PWM waveform.
- BUSY  output  1  high in ARM and RUN.
- DONE  output  1  one-cycle pulse at normal burst completion.

Behaviour:
- Counter M is tied 0 (up-count) at top level; this block never drives M.
- Reset (async, RST=1): state=IDLE; PWM=0, BUSY=0, DONE=0, LD_OUT=0, CE_OUT=0, D_OUT=0; internal duty_act=0, rem=0.
- All outputs registered; no combinational input-to-output paths.
- States: IDLE, ARM, RUN, FIN.
- IDLE: CE_OUT=0, PWM=0. START=1 with NPULSE!=0 -> latch duty_act<=DUTY, rem<=NPULSE, go ARM. START=1 with NPULSE==0 -> DONE=1 next cycle, stay IDLE (no counter activity).
- ARM (exactly 1 cycle): LD_OUT=1, D_OUT=0, CE_OUT=0, so the counter loads 0 on the next edge; -> RUN.
- RUN: LD_OUT=0, CE_OUT=1. Each edge, PWM<=(Q<duty_act), so PWM lags Q by one clock. DUTY=0 gives constant low; DUTY=15 gives 15 high / 1 low per period.
- Period boundary = edge at which CO=1 in RUN:
  - rem<=rem-1.
  - duty_act<=DUTY. DUTY changes mid-period take effect only at the next boundary; no glitch or short pulse.
  - If rem==1 at the boundary -> FIN.
- FIN (1 cycle): DONE=1, CE_OUT=0, PWM=0, BUSY=0; -> IDLE.
- Burst latency: START edge to first PWM high = 3 edges (ARM, load, compare) when DUTY!=0. Total RUN length = 16*NPULSE cycles.
- STOP=1 in any state: -> IDLE next edge; PWM=0, CE_OUT=0, LD_OUT=0, no DONE pulse. STOP and START in the same cycle: STOP wins.
- START while BUSY: ignored.
- rem never wraps: decrement only in RUN with rem>=1.
- CO outside RUN: ignored.
- RST asserted mid-burst: immediate return to reset values; no DONE pulse.

Optional Feature:
- Macro PWM_BURST_CONT_EN.
- Defined: NPULSE==0 with START selects continuous mode. Enter ARM/RUN; rem is not decremented; PWM runs until STOP; DONE is never pulsed in this mode. DUTY still updates at each CO boundary.
- Undefined: NPULSE==0 with START gives the immediate one-cycle DONE described above. The continuous-mode logic is absent.

Test Plan:
- Reset: RST=1 mid-RUN -> all outputs 0 immediately (before next CLK edge); after release, state IDLE, BUSY=0.
- DUTY=4, NPULSE=2, START pulse -> LD_OUT=1 one cycle; PWM high 4 / low 12 per period for exactly 2 periods (32 RUN cycles); DONE=1 one cycle; CE_OUT=0 afterwards.
- DUTY=0 and DUTY=15, NPULSE=1 -> PWM constant 0 / PWM high 15 cycles then low 1; DONE after 16 RUN cycles.
- DUTY changed 4->10 at Q=7 of period 1, NPULSE=3 -> period 1 keeps 4 high; periods 2 and 3 show 10 high.
- STOP at Q=5 of period 2 (NPULSE=5) -> next edge PWM=0, CE_OUT=0, BUSY=0, DONE never asserts; a new START then behaves normally.
- NPULSE=0, START -> without macro: DONE=1 one cycle, LD_OUT/CE_OUT stay 0. With PWM_BURST_CONT_EN: PWM runs 40+ periods, then STOP -> IDLE, no DONE.
